// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared types and constants for the branch redirect controller and its branch unit.
package branch_redirect_ctrl_pkg;

   typedef logic [31:0] word;

   typedef enum logic [2:0] {
      BR_EQ,
      BR_NE,
      BR_LT,
      BR_GE,
      BR_LTU,
      BR_GEU
   } branch_op_t;

   typedef enum logic {
      BRANCH_DISABLE,
      BRANCH_ENABLE
   } branch_en_t;

   typedef enum logic [1:0] {
      KIND_BRANCH,
      KIND_JAL,
      KIND_JALR
   } ctrl_kind_t;

   typedef enum logic [1:0] {
      IDLE,
      RESOLVE,
      REDIRECT,
      FLUSH
   } ctrl_state_t;

   localparam word INST_WIDTH_BYTES = 32'd4;

endpackage

// File: rtl/branch_redirect_if.sv
// Decode request, fetch redirect and execute side-band signals of the redirect controller.
interface branch_redirect_if;
   import branch_redirect_ctrl_pkg::*;

   logic       req_valid;
   logic       req_ready;
   ctrl_kind_t req_kind;
   branch_op_t req_op;
   word        req_pc;
   word        req_rs1;
   word        req_rs2;
   word        req_offset;
   logic       req_pred_taken;
   logic       redirect_valid;
   logic       redirect_ready;
   word        redirect_pc;
   logic       flush;
   logic       squash;
   logic       link_valid;
   word        link_data;
   logic       trap_valid;
   word        trap_tval;

   modport master (
      output req_valid, req_kind, req_op, req_pc, req_rs1, req_rs2, req_offset,
             req_pred_taken, redirect_ready,
      input  req_ready, redirect_valid, redirect_pc, flush, squash,
             link_valid, link_data, trap_valid, trap_tval
   );

   modport slave (
      input  req_valid, req_kind, req_op, req_pc, req_rs1, req_rs2, req_offset,
             req_pred_taken, redirect_ready,
      output req_ready, redirect_valid, redirect_pc, flush, squash,
             link_valid, link_data, trap_valid, trap_tval
   );

endinterface

// File: rtl/branch_redirect_ctrl_branch_unit.sv
// Conditional-branch evaluator: condition success flag and pc-relative target.
module branch_unit
   import branch_redirect_ctrl_pkg::*;
(
   input  branch_op_t op,
   input  word        rs1,
   input  word        rs2,
   input  word        pc,
   input  word        offset,
   output branch_en_t branch_scs,
   output word        branch_address
);

   logic cond;

   always_comb begin
      cond = 1'b0;
      case (op)
         BR_EQ:   cond = (rs1 == rs2);
         BR_NE:   cond = (rs1 != rs2);
         BR_LT:   cond = ($signed(rs1) <  $signed(rs2));
         BR_GE:   cond = ($signed(rs1) >= $signed(rs2));
         BR_LTU:  cond = (rs1 <  rs2);
         BR_GEU:  cond = (rs1 >= rs2);
         default: cond = 1'b0;
      endcase
      branch_scs = cond ? BRANCH_ENABLE : BRANCH_DISABLE;
   end

   assign branch_address = pc + offset;

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Execute-stage control-transfer sequencer: resolve, redirect fetch, squash window.
// Optional build macro BRANCH_PREDICT_EN: redirect only on misprediction.
//
// state    | meaning
// IDLE     | ready for a decode request
// RESOLVE  | captured request evaluated; link/trap pulses issued
// REDIRECT | redirect_valid held until fetch accepts
// FLUSH    | squash asserted for FLUSH_CYCLES cycles
module branch_redirect_ctrl
   import branch_redirect_ctrl_pkg::*;
#(
   parameter int FLUSH_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst,
   branch_redirect_if.slave bus
);

   localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

   ctrl_state_t state, state_nxt;
   ctrl_kind_t  kind_q;
   branch_op_t  op_q;
   word         pc_q, rs1_q, rs2_q, offset_q;
   word         redirect_pc_q;
   logic [3:0]  cnt;
   branch_en_t  branch_scs;
   word         branch_address;
   word         target;
   logic        need_redirect;
   logic        misaligned;
   logic        is_jump;
   logic        handshake;

`ifdef BRANCH_PREDICT_EN
   logic        pred_q;
`endif

   branch_unit u_branch_unit (
      .op             (op_q),
      .rs1            (rs1_q),
      .rs2            (rs2_q),
      .pc             (pc_q),
      .offset         (offset_q),
      .branch_scs     (branch_scs),
      .branch_address (branch_address)
   );

   always_comb begin
      need_redirect = 1'b0;
      target        = '0;
      case (kind_q)
`ifdef BRANCH_PREDICT_EN
         KIND_BRANCH: begin
            if ((branch_scs == BRANCH_ENABLE) && !pred_q) begin
               need_redirect = 1'b1;
               target        = branch_address;
            end else if ((branch_scs != BRANCH_ENABLE) && pred_q) begin
               need_redirect = 1'b1;
               target        = pc_q + INST_WIDTH_BYTES;
            end
         end
         // fetch already followed a predicted JAL
         KIND_JAL: begin
            need_redirect = !pred_q;
            target        = pc_q + offset_q;
         end
`else
         KIND_BRANCH: begin
            need_redirect = (branch_scs == BRANCH_ENABLE);
            target        = branch_address;
         end
         KIND_JAL: begin
            need_redirect = 1'b1;
            target        = pc_q + offset_q;
         end
`endif
         KIND_JALR: begin
            need_redirect = 1'b1;
            target        = (rs1_q + offset_q) & ~32'h1;
         end
         default: begin
            need_redirect = 1'b0;
            target        = '0;
         end
      endcase
   end

   assign misaligned = (target[1:0] != 2'b00);
   assign is_jump    = (kind_q == KIND_JAL) || (kind_q == KIND_JALR);
   assign handshake  = (state == REDIRECT) && bus.redirect_ready;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (bus.req_valid) state_nxt = RESOLVE;
         RESOLVE:  state_nxt = (need_redirect && !misaligned) ? REDIRECT : IDLE;
         REDIRECT: if (bus.redirect_ready) state_nxt = FLUSH;
         FLUSH:    if (cnt == 4'd0) state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         kind_q        <= KIND_BRANCH;
         op_q          <= BR_EQ;
         pc_q          <= '0;
         rs1_q         <= '0;
         rs2_q         <= '0;
         offset_q      <= '0;
         redirect_pc_q <= '0;
         cnt           <= '0;
`ifdef BRANCH_PREDICT_EN
         pred_q        <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
         if ((state == IDLE) && bus.req_valid) begin
            kind_q   <= bus.req_kind;
            op_q     <= bus.req_op;
            pc_q     <= bus.req_pc;
            rs1_q    <= bus.req_rs1;
            rs2_q    <= bus.req_rs2;
            offset_q <= bus.req_offset;
`ifdef BRANCH_PREDICT_EN
            pred_q   <= bus.req_pred_taken;
`endif
         end
         if ((state == RESOLVE) && need_redirect && !misaligned)
            redirect_pc_q <= target;
         if (handshake)
            cnt <= CNT_LOAD;
         else if ((state == FLUSH) && (cnt != 4'd0))
            cnt <= cnt - 4'd1;
      end
   end

   // req_ready is gated by rst so it reads 0 throughout reset, not just after the edge
   assign bus.req_ready      = (state == IDLE) && !rst;
   assign bus.redirect_valid = (state == REDIRECT);
   assign bus.redirect_pc    = redirect_pc_q;
   assign bus.flush          = handshake;
   assign bus.squash         = (state == FLUSH);
   assign bus.link_valid     = (state == RESOLVE) && is_jump;
   assign bus.link_data      = bus.link_valid ? (pc_q + INST_WIDTH_BYTES) : '0;
   assign bus.trap_valid     = (state == RESOLVE) && need_redirect && misaligned;
   assign bus.trap_tval      = bus.trap_valid ? target : '0;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed self-checking bench for branch_redirect_ctrl with hand-computed expectations.
module tb_branch_redirect_ctrl;
   import branch_redirect_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   branch_redirect_if bus ();

   branch_redirect_ctrl #(.FLUSH_CYCLES(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      while (!bus.req_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!bus.req_ready) check(tag, {31'b0, bus.req_ready}, 32'd1);
   endtask

   // returns at the negedge of cycle N+1 (RESOLVE)
   task automatic send(input ctrl_kind_t k, input branch_op_t op, input word pc,
                       input word rs1, input word rs2, input word off, input logic pred);
      wait_ready("send_ready_timeout");
      bus.req_kind       = k;
      bus.req_op         = op;
      bus.req_pc         = pc;
      bus.req_rs1        = rs1;
      bus.req_rs2        = rs2;
      bus.req_offset     = off;
      bus.req_pred_taken = pred;
      bus.req_valid      = 1'b1;
      @(negedge clk);
      bus.req_valid      = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic flush_seen;
      logic rv_seen;

      bus.req_valid      = 1'b0;
      bus.req_kind       = KIND_BRANCH;
      bus.req_op         = BR_EQ;
      bus.req_pc         = '0;
      bus.req_rs1        = '0;
      bus.req_rs2        = '0;
      bus.req_offset     = '0;
      bus.req_pred_taken = 1'b0;
      bus.redirect_ready = 1'b0;

      // reset values
      @(negedge clk);
      @(negedge clk);
      check("rst_req_ready", {31'b0, bus.req_ready}, 32'd0);
      check("rst_redirect_valid", {31'b0, bus.redirect_valid}, 32'd0);
      check("rst_squash", {31'b0, bus.squash}, 32'd0);
      check("rst_link_valid", {31'b0, bus.link_valid}, 32'd0);
      check("rst_redirect_pc", bus.redirect_pc, 32'h0);
      rst = 1'b0;
      #1;
      check("post_rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
      @(negedge clk);

      // BEQ taken, immediate ready
      bus.redirect_ready = 1'b1;
      send(KIND_BRANCH, BR_EQ, 32'h100, 32'd5, 32'd5, 32'h20, 1'b0);
      check("beq_n1_link", {31'b0, bus.link_valid}, 32'd0);
      check("beq_n1_trap", {31'b0, bus.trap_valid}, 32'd0);
      check("beq_n1_rv", {31'b0, bus.redirect_valid}, 32'd0);
      check("beq_n1_ready", {31'b0, bus.req_ready}, 32'd0);
      @(negedge clk);
      check("beq_n2_rv", {31'b0, bus.redirect_valid}, 32'd1);
      check("beq_n2_pc", bus.redirect_pc, 32'h120);
      check("beq_n2_flush", {31'b0, bus.flush}, 32'd1);
      @(negedge clk);
      check("beq_n3_squash", {31'b0, bus.squash}, 32'd1);
      check("beq_n3_flush", {31'b0, bus.flush}, 32'd0);
      check("beq_n3_rv", {31'b0, bus.redirect_valid}, 32'd0);
      @(negedge clk);
      check("beq_n4_squash", {31'b0, bus.squash}, 32'd1);
      check("beq_n4_ready", {31'b0, bus.req_ready}, 32'd0);
      @(negedge clk);
      check("beq_n5_squash", {31'b0, bus.squash}, 32'd0);
      check("beq_n5_ready", {31'b0, bus.req_ready}, 32'd1);

      // BLTU 0xFFFFFFFF < 1 is false
      send(KIND_BRANCH, BR_LTU, 32'h180, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b1);
      check("bltu_n1_rv", {31'b0, bus.redirect_valid}, 32'd0);
      @(negedge clk);
`ifdef BRANCH_PREDICT_EN
      check("bltu_pred_rv", {31'b0, bus.redirect_valid}, 32'd1);
      check("bltu_pred_pc", bus.redirect_pc, 32'h184);
`else
      check("bltu_n2_rv", {31'b0, bus.redirect_valid}, 32'd0);
      check("bltu_n2_ready", {31'b0, bus.req_ready}, 32'd1);
`endif

      // JALR aligned: (0x203+1)&~1 = 0x204
      send(KIND_JALR, BR_EQ, 32'h40, 32'h203, 32'h0, 32'h1, 1'b0);
      check("jalr_link_valid", {31'b0, bus.link_valid}, 32'd1);
      check("jalr_link_data", bus.link_data, 32'h44);
      check("jalr_trap", {31'b0, bus.trap_valid}, 32'd0);
      @(negedge clk);
      check("jalr_rv", {31'b0, bus.redirect_valid}, 32'd1);
      check("jalr_pc", bus.redirect_pc, 32'h204);
      check("jalr_flush", {31'b0, bus.flush}, 32'd1);

      // JALR misaligned: 0x202 traps, no redirect
      send(KIND_JALR, BR_EQ, 32'h40, 32'h201, 32'h0, 32'h1, 1'b0);
      check("jalr_mis_link", {31'b0, bus.link_valid}, 32'd1);
      check("jalr_mis_link_data", bus.link_data, 32'h44);
      check("jalr_mis_trap", {31'b0, bus.trap_valid}, 32'd1);
      check("jalr_mis_tval", bus.trap_tval, 32'h202);
      @(negedge clk);
      check("jalr_mis_rv", {31'b0, bus.redirect_valid}, 32'd0);
      check("jalr_mis_ready", {31'b0, bus.req_ready}, 32'd1);
      check("jalr_mis_trap_gone", {31'b0, bus.trap_valid}, 32'd0);

      // redirect stalled for 5 cycles, stray req_valid ignored
      bus.redirect_ready = 1'b0;
      send(KIND_JAL, BR_EQ, 32'h300, 32'h0, 32'h0, 32'h10, 1'b0);
      check("stall_link_data", bus.link_data, 32'h304);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall_rv", {31'b0, bus.redirect_valid}, 32'd1);
         check("stall_pc", bus.redirect_pc, 32'h310);
         check("stall_flush", {31'b0, bus.flush}, 32'd0);
         check("stall_ready", {31'b0, bus.req_ready}, 32'd0);
         if (i == 1) begin
            bus.req_kind  = KIND_JALR;
            bus.req_pc    = 32'h999;
            bus.req_rs1   = 32'h777;
            bus.req_valid = 1'b1;
         end
         if (i == 3) bus.req_valid = 1'b0;
      end
      bus.redirect_ready = 1'b1;
      #1;
      check("stall_hs_flush", {31'b0, bus.flush}, 32'd1);
      check("stall_hs_pc", bus.redirect_pc, 32'h310);
      @(negedge clk);
      check("stall_post_squash", {31'b0, bus.squash}, 32'd1);
      check("stall_post_flush", {31'b0, bus.flush}, 32'd0);
      wait_ready("stall_idle_timeout");
      @(negedge clk);
      check("stall_no_capture", {31'b0, bus.link_valid}, 32'd0);

      // reset one cycle into REDIRECT
      bus.redirect_ready = 1'b0;
      send(KIND_BRANCH, BR_EQ, 32'h500, 32'd7, 32'd7, 32'h40, 1'b0);
      @(negedge clk);
      check("rstmid_rv_before", {31'b0, bus.redirect_valid}, 32'd1);
      check("rstmid_pc_before", bus.redirect_pc, 32'h540);
      #2;
      rst = 1'b1;
      #1;
      check("rstmid_rv", {31'b0, bus.redirect_valid}, 32'd0);
      check("rstmid_pc", bus.redirect_pc, 32'h0);
      check("rstmid_flush", {31'b0, bus.flush}, 32'd0);
      check("rstmid_squash", {31'b0, bus.squash}, 32'd0);
      check("rstmid_ready", {31'b0, bus.req_ready}, 32'd0);
      bus.redirect_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rstmid_release_ready", {31'b0, bus.req_ready}, 32'd1);
      flush_seen = 1'b0;
      rv_seen    = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         flush_seen = flush_seen | bus.flush;
         rv_seen    = rv_seen | bus.redirect_valid;
      end
      check("rstmid_no_flush", {31'b0, flush_seen}, 32'd0);
      check("rstmid_no_rv", {31'b0, rv_seen}, 32'd0);

      // BGE signed: -1 >= 0 false
      send(KIND_BRANCH, BR_GE, 32'h600, 32'hFFFF_FFFF, 32'h0, 32'h8, 1'b0);
      @(negedge clk);
      check("bge_rv", {31'b0, bus.redirect_valid}, 32'd0);
      // BGEU unsigned: 0xFFFFFFFF >= 0 true
      send(KIND_BRANCH, BR_GEU, 32'h600, 32'hFFFF_FFFF, 32'h0, 32'h8, 1'b0);
      @(negedge clk);
      check("bgeu_rv", {31'b0, bus.redirect_valid}, 32'd1);
      check("bgeu_pc", bus.redirect_pc, 32'h608);
      check("bgeu_flush", {31'b0, bus.flush}, 32'd1);

      // JAL wrap-around target is legal
      send(KIND_JAL, BR_EQ, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h8, 1'b0);
      check("wrap_trap", {31'b0, bus.trap_valid}, 32'd0);
      check("wrap_link_data", bus.link_data, 32'h0);
      @(negedge clk);
      check("wrap_rv", {31'b0, bus.redirect_valid}, 32'd1);
      check("wrap_pc", bus.redirect_pc, 32'h4);
      wait_ready("wrap_idle_timeout");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
